// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised init-swept single-port RAM.
// Build option RAM_WRITE_FIRST_EN: when defined, a RUN-state write also
// drives the written data onto out on the same edge (write-first); when
// undefined, out returns the word's previous contents (read-first, legacy).
package ram_pkg;

  // Sequencer state encoding
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_t;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_ADDR_W = 3;

endpackage : ram_pkg

// File: rtl/ram_init_seq.sv
// Init sequencer: sweeps every address after reset or clear, then enters RUN.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              run,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  ram_state_t       state;
  logic [CNT_W-1:0] cnt;

  // State, sweep counter and ready; clear restarts the sweep from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (clear) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Write-port control decoded straight from the state register
  assign init_we   = (state == ST_INIT);
  assign init_addr = cnt[ADDR_W-1:0];
  assign run       = (state == ST_RUN);

endmodule : ram_init_seq

// File: rtl/ram_init_sync.sv
// Parametrised synchronous single-port RAM with a built-in init sweep.
// Build option RAM_WRITE_FIRST_EN selects write-first read-during-write;
// the default build is read-first.
module ram_init_sync
  import ram_pkg::*;
#(
  parameter int unsigned       WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic [WIDTH-1:0]  in,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              run;
  logic              user_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;

  ram_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .init_we   (init_we),
    .init_addr (init_addr),
    .run       (run),
    .ready     (ready)
  );

  // Write-port mux: sweep owns the port in INIT; a user load racing clear is dropped
  assign user_we = run & load & ~clear;
  assign we      = init_we | user_we;
  assign waddr   = init_we ? init_addr : address;
  assign wdata   = init_we ? INIT_VALUE : in;

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef RAM_WRITE_FIRST_EN
  assign rdata = user_we ? in : mem[address];
`else
  assign rdata = mem[address];
`endif

  // Registered read data, forced to zero outside RUN and on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (clear || !run) begin
      out <= '0;
    end else begin
      out <= rdata;
    end
  end

endmodule : ram_init_sync

// File: tb/tb_ram_init_sync.sv
// Directed self-checking bench for ram_init_sync (WIDTH=16, ADDR_W=3).
module tb_ram_init_sync;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;
  localparam logic [WIDTH-1:0] IV = 16'hA5A5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic              load;
  logic [WIDTH-1:0]  in;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              ready;

  int checks = 0;
  int errors = 0;

  ram_init_sync #(
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .INIT_VALUE (IV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .load    (load),
    .in      (in),
    .clear   (clear),
    .out     (out),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address = '0; load = 1'b0; in = '0; clear = 1'b0;
    tick(); tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h exp 0000", out); end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL sweep_ready_low edge %0d got %b exp 0", i, ready); end
      tick();
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL sweep_ready_high got %b exp 1", ready); end
  endtask

  task automatic test_init_sweep();
    for (int a = 0; a < DEPTH; a++) begin
      address = ADDR_W'(a);
      tick();
      checks++;
      if (out !== IV) begin errors++; $display("FAIL init_read addr %0d got %h exp %h", a, out, IV); end
    end
  endtask

  task automatic test_write_read();
    address = 3'd5; load = 1'b1; in = 16'h1234;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (out !== 16'h1234) begin errors++; $display("FAIL write_read addr5 got %h exp 1234", out); end
    address = 3'd4;
    tick();
    checks++;
    if (out !== IV) begin errors++; $display("FAIL write_read addr4 got %h exp %h", out, IV); end
  endtask

  task automatic test_rdw();
    logic [WIDTH-1:0] exp;
`ifdef RAM_WRITE_FIRST_EN
    exp = 16'hBEEF;
`else
    exp = IV;
`endif
    address = 3'd3; load = 1'b1; in = 16'hBEEF;
    tick();
    load = 1'b0;
    checks++;
    if (out !== exp) begin errors++; $display("FAIL rdw_out got %h exp %h", out, exp); end
    tick();
    checks++;
    if (out !== 16'hBEEF) begin errors++; $display("FAIL rdw_after got %h exp beef", out); end
  endtask

  task automatic test_clear();
    // clear with a racing load to 5, held for three edges
    address = 3'd5; load = 1'b1; in = 16'h5555; clear = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (ready !== 1'b0 || out !== 16'h0000) begin
      errors++; $display("FAIL clear_edge ready %b out %h exp 0 0000", ready, out);
    end
    tick(); tick();
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_low edge %0d got %b exp 0", i, ready); end
      tick();
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL clear_ready_high got %b exp 1", ready); end
    address = 3'd5;
    tick();
    checks++;
    if (out !== IV) begin errors++; $display("FAIL clear_addr5 got %h exp %h", out, IV); end
    address = 3'd3;
    tick();
    checks++;
    if (out !== IV) begin errors++; $display("FAIL clear_addr3 got %h exp %h", out, IV); end
  endtask

  task automatic test_load_during_init();
    address = 3'd2; load = 1'b1; in = 16'h7777;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (out !== 16'h7777) begin errors++; $display("FAIL pre_init_write got %h exp 7777", out); end
    clear = 1'b1;
    tick();
    clear = 1'b0; load = 1'b1; in = 16'h0001; address = 3'd2;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL init_out_zero edge %0d got %h exp 0000", i, out); end
      tick();
    end
    load = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL init_load_ready got %b exp 1", ready); end
    tick();
    checks++;
    if (out !== IV) begin errors++; $display("FAIL init_load_addr2 got %h exp %h", out, IV); end
  endtask

  task automatic test_async_reset();
    // mid-RUN: out holds A5A5 at address 2
    checks++;
    if (out !== IV) begin errors++; $display("FAIL run_out_pre got %h exp %h", out, IV); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || ready !== 1'b0) begin
      errors++; $display("FAIL async_run out %h ready %b exp 0000 0", out, ready);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    // sweep counter is 4 here; reset again mid-sweep
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || ready !== 1'b0) begin
      errors++; $display("FAIL async_sweep out %h ready %b exp 0000 0", out, ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low edge %0d got %b exp 0", i, ready); end
      tick();
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high got %b exp 1", ready); end
    address = 3'd7;
    tick();
    checks++;
    if (out !== IV) begin errors++; $display("FAIL rst_addr7 got %h exp %h", out, IV); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_write_read();
    test_rdw();
    test_clear();
    test_load_during_init();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_init_sync
